// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath strobes. Optional trap on undefined opcodes: MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN.
module multicycle_control #(
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [5:0]         Op_i,
    input  logic               Zero_i,
    input  logic               mem_ack_i,
    output logic               PCWrite_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic               MDRWrite_o,
    output logic               RegDst_o,
    output logic               MemtoReg_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic [1:0]         PCSource_o,
    output logic [3:0]         state_o,
    output logic               timeout_o,
    output logic               illegal_o
);

    localparam int unsigned CNT_W = 8;

    localparam logic [CNT_W-1:0]   TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
    localparam logic [ALUOP_W-1:0] ALU_ADD     = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB     = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT   = ALUOP_W'(3);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_R     = 4'd8,
        S_WB_I     = 4'd9,
        S_WB_MEM   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_TIMEOUT  = 4'd13,
        S_TRAP     = 4'd14
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic             wait_expired;

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif

    assign state_o      = state_q;
    assign timeout_o    = timeout_q;
    assign wait_expired = (wait_cnt_q == TIMEOUT_CNT);

    // State register, memory wait counter and sticky flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    // Next state and state-decoded strobes; counter clears whenever it is not explicitly advanced
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        PCWrite_o  = 1'b0;
        IorD_o     = 1'b0;
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        IRWrite_o  = 1'b0;
        MDRWrite_o = 1'b0;
        RegDst_o   = 1'b0;
        MemtoReg_o = 1'b0;
        RegWrite_o = 1'b0;
        ALUSrcA_o  = 1'b0;
        ALUSrcB_o  = 2'b00;
        ALUOp_o    = ALU_ADD;
        PCSource_o = 2'b00;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                if (mem_ack_i) begin
                    IRWrite_o = 1'b1;
                    PCWrite_o = 1'b1;
                    state_d   = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                ALUSrcB_o = 2'b11;
                case (Op_i)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = ALU_FUNCT;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                RegDst_o   = 1'b1;
                RegWrite_o = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_I: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                RegWrite_o = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                state_d   = (Op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
                if (mem_ack_i) begin
                    MDRWrite_o = 1'b1;
                    state_d    = S_WB_MEM;
                end else if (wait_expired) begin
                    state_d = S_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_MEM_WR: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
                if (mem_ack_i) begin
                    state_d = S_FETCH;
                end else if (wait_expired) begin
                    state_d = S_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_WB_MEM: begin
                MemtoReg_o = 1'b1;
                RegWrite_o = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA_o  = 1'b1;
                ALUOp_o    = ALU_SUB;
                PCSource_o = 2'b01;
                PCWrite_o  = Zero_i;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                PCSource_o = 2'b10;
                PCWrite_o  = 1'b1;
                state_d    = S_FETCH;
            end
            S_TIMEOUT, S_TRAP: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        timeout_d = timeout_q | (state_d == S_TIMEOUT);
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q | (state_d == S_TRAP);
`endif
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS main control FSM, the successor to the single-cycle opcode decoder.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction.
- Drives datapath mux/enable strobes and handshakes with a shared instruction/data memory via mem_ack_i.
- Adds lw, sw, beq and j to R-type and addi, plus a memory-wait timeout.

Parameters:
- ALUOP_W, 2, width of ALUOp_o. Encodings are zero-extended: 00 add, 01 sub, 11 R-type/funct.
- MEM_TIMEOUT, 15, max cycles to wait for mem_ack_i in a memory state before TIMEOUT (range 1..255).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  leave IDLE and begin fetching.
- Op_i  in  6  opcode field from the instruction register (valid from DECODE onward).
- Zero_i  in  1  ALU zero flag, sampled in BRANCH.
- mem_ack_i  in  1  memory completes the current request this cycle.
- PCWrite_o  out  1  PC load enable.
- IorD_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead_o  out  1  memory read request.
- MemWrite_o  out  1  memory write request.
- IRWrite_o  out  1  instruction register load.
- MDRWrite_o  out  1  memory data register load.
- RegDst_o  out  1  1 = rd, 0 = rt.
- MemtoReg_o  out  1  1 = MDR, 0 = ALUOut.
- RegWrite_o  out  1  register file write enable.
- ALUSrcA_o  out  1  0 = PC, 1 = rs.
- ALUSrcB_o  out  2  00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = immediate<<2.
- ALUOp_o  out  ALUOP_W  ALU control class.
- PCSource_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state_o  out  4  current state encoding (debug).
- timeout_o  out  1  sticky memory-timeout flag.
- illegal_o  out  1  sticky illegal-opcode flag (only driven with the optional feature; else tied 0).

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_R=8, WB_I=9, WB_MEM=10, BRANCH=11, JUMP=12, TIMEOUT=13, TRAP=14.
- Reset: state=IDLE, wait counter=0, timeout_o=0, illegal_o=0.
- Output decode: all outputs are decoded from state, so every output is 0 in IDLE. Exceptions are the strobes qualified by mem_ack_i, listed below.
- IDLE: goes to FETCH when start_i=1.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
  - IRWrite and PCWrite are asserted only in the cycle mem_ack_i=1; the FSM then goes to DECODE.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=add (branch target into ALUOut).
  - Next state by Op_i: 000000 -> EXEC_R; 001000 -> EXEC_I; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; any other opcode -> see Optional Feature.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=11; goes to WB_R.
- WB_R: RegDst=1, MemtoReg=0, RegWrite=1; goes to FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00; goes to WB_I.
- WB_I: RegDst=0, MemtoReg=0, RegWrite=1; goes to FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_RD for lw (100011) and MEM_WR for sw (101011); Op_i is held stable by the IR.
- MEM_RD: MemRead=1, IorD=1. MDRWrite is asserted in the ack cycle, then the FSM goes to WB_MEM.
- MEM_WR: MemWrite=1, IorD=1; goes to FETCH on ack.
- WB_MEM: RegDst=0, MemtoReg=1, RegWrite=1; goes to FETCH.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01.
  - PCWrite = Zero_i (combinational). Goes to FETCH.
- JUMP: PCSource=10, PCWrite=1; goes to FETCH.
- Latency with zero-wait memory (ack in the first cycle): R/addi/sw/beq/j take 4/4/4/3/3 cycles; lw takes 5.
- Memory wait counter (8 bits):
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle the FSM waits there without ack.
  - When the counter equals MEM_TIMEOUT and ack is still 0, the next state is TIMEOUT.
  - Ack arriving in the same cycle the count reaches MEM_TIMEOUT wins: normal progress, no timeout.
- TIMEOUT: all outputs 0; timeout_o set and held; the FSM stays here until reset.
- start_i is ignored outside IDLE.
- Reset mid-instruction: returns to IDLE immediately (async). In-flight strobes drop the same instant; no partial register write occurs after reset assertion.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in DECODE goes to TRAP. illegal_o is set sticky, all strobes are 0, and the FSM stays until reset.
- Undefined: an undefined opcode in DECODE goes to FETCH (treated as NOP; PC was already advanced in FETCH); illegal_o is tied 0 and TRAP is unreachable.

Test Plan:
- Reset, start_i=1, Op_i=000000, ack every fetch -> states 1,2,3,8; RegWrite=1 and RegDst=1 only in WB_R; ALUOp=11 in EXEC_R.
- lw (100011) with mem_ack_i delayed 3 cycles in both FETCH and MEM_RD -> IRWrite pulses once, then MDRWrite pulses once, each in its ack cycle; MemtoReg=1 in WB_MEM; 11 cycles total.
- beq with Zero_i=1, then beq with Zero_i=0 -> PCWrite=1 in BRANCH only for the first; PCSource=01 in both.
- Hold mem_ack_i=0 in FETCH with MEM_TIMEOUT=15 -> TIMEOUT entered after 16 FETCH cycles, timeout_o=1; ack asserted in the 16th cycle instead -> goes to DECODE, no timeout.
- Op_i=111111 -> with the macro: state 14, illegal_o=1; without: back to FETCH, illegal_o=0.
- Assert rst_n_i=0 asynchronously mid-MEM_WR -> MemWrite_o falls without a clock edge; state_o=0; restart with start_i works normally.
